// File: rtl/fb_fill_engine.sv
// fb_fill_engine: rectangle-fill writer for frame buffer port B.
//
// Takes a rectangle (rect_x, rect_y, rect_w, rect_h) and a 12-bit colour,
// clips it to the FB_WIDTH x FB_HEIGHT screen and writes one pixel per clock,
// row-major, into the frame buffer. Reports busy/done/clipped to the host.
//
// Ports:
//   clock, nreset            core clock, asynchronous active-low reset
//   start                    one-cycle request, sampled only when idle
//   rect_x/rect_y            top-left corner
//   rect_w/rect_h            size in pixels / rows
//   color                    fill value
//   abort                    cancel request (only used with FB_FILL_ABORT_EN)
//   busy, done, clipped      status (all registered)
//   fb_wen, fb_addr, fb_din  frame buffer write port (all registered)
//
// Optional feature: define FB_FILL_ABORT_EN to honour abort in SETUP/FILL.
//
// Outputs are registered from the state the FSM is in, so every output
// shows the action of the previous cycle's state: the first write appears
// two cycles after start is accepted and done follows the last write.
module fb_fill_engine #(
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 120,
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int ADDR_W    = 15,
  parameter int PIX_W     = 12
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              start,
  input  logic [X_W-1:0]    rect_x,
  input  logic [Y_W-1:0]    rect_y,
  input  logic [X_W-1:0]    rect_w,
  input  logic [Y_W-1:0]    rect_h,
  input  logic [PIX_W-1:0]  color,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              clipped,
  output logic              fb_wen,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [PIX_W-1:0]  fb_din
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    FILL   = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [X_W:0]        FBW_L    = (X_W+1)'(FB_WIDTH);
  localparam logic [Y_W:0]        FBH_L    = (Y_W+1)'(FB_HEIGHT);
  localparam logic [ADDR_W-1:0]   ROW_STEP = ADDR_W'(FB_WIDTH);

  state_t              state_r, state_nx;
  logic [X_W-1:0]      x_r, x_nx, w_r, w_nx, col_r, col_nx;
  logic [Y_W-1:0]      y_r, y_nx, h_r, h_nx, row_r, row_nx;
  logic [PIX_W-1:0]    color_r, color_nx;
  logic [X_W:0]        ew_r, ew_nx;
  logic [Y_W:0]        eh_r, eh_nx;
  logic [ADDR_W-1:0]   row_base_r, row_base_nx;
  logic                busy_r, busy_nx, done_r, done_nx, clipped_r, clipped_nx;
  logic                fb_wen_r, fb_wen_nx;
  logic [ADDR_W-1:0]   fb_addr_r, fb_addr_nx;
  logic [PIX_W-1:0]    fb_din_r, fb_din_nx;

  // Clipping arithmetic on the latched request (one bit wider so room never
  // overflows; only meaningful when the corner is on screen).
  logic                x_ok_s, y_ok_s, reject_s, clip_s, abort_s;
  logic [X_W:0]        room_x_s, ew_s;
  logic [Y_W:0]        room_y_s, eh_s;
  logic [ADDR_W-1:0]   row_base_s;

`ifdef FB_FILL_ABORT_EN
  assign abort_s = abort;
`else
  logic unused_abort_s;
  assign unused_abort_s = abort;
  assign abort_s        = 1'b0;
`endif

  assign x_ok_s     = ({1'b0, x_r} < FBW_L);
  assign y_ok_s     = ({1'b0, y_r} < FBH_L);
  assign room_x_s   = FBW_L - {1'b0, x_r};
  assign room_y_s   = FBH_L - {1'b0, y_r};
  assign ew_s       = ({1'b0, w_r} < room_x_s) ? {1'b0, w_r} : room_x_s;
  assign eh_s       = ({1'b0, h_r} < room_y_s) ? {1'b0, h_r} : room_y_s;
  assign row_base_s = ADDR_W'(y_r) * ROW_STEP + ADDR_W'(x_r);
  assign reject_s   = !x_ok_s || !y_ok_s || (w_r == X_W'(0)) || (h_r == Y_W'(0));
  // Off-screen corners count as clipped even with a zero size.
  assign clip_s     = !x_ok_s || !y_ok_s || (ew_s < {1'b0, w_r}) || (eh_s < {1'b0, h_r});

  // Next-state and next-output logic.
  always_comb begin
    state_nx    = state_r;
    x_nx        = x_r;
    y_nx        = y_r;
    w_nx        = w_r;
    h_nx        = h_r;
    color_nx    = color_r;
    ew_nx       = ew_r;
    eh_nx       = eh_r;
    col_nx      = col_r;
    row_nx      = row_r;
    row_base_nx = row_base_r;
    busy_nx     = busy_r;
    done_nx     = 1'b0;
    clipped_nx  = clipped_r;
    fb_wen_nx   = 1'b0;
    fb_addr_nx  = fb_addr_r;
    fb_din_nx   = fb_din_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          x_nx       = rect_x;
          y_nx       = rect_y;
          w_nx       = rect_w;
          h_nx       = rect_h;
          color_nx   = color;
          clipped_nx = 1'b0;
          busy_nx    = 1'b1;
          state_nx   = SETUP;
        end else begin
          state_nx = IDLE;
        end
      end
      SETUP: begin
        ew_nx       = ew_s;
        eh_nx       = eh_s;
        row_base_nx = row_base_s;
        col_nx      = X_W'(0);
        row_nx      = Y_W'(0);
        clipped_nx  = clip_s;
        if (abort_s || reject_s) begin
          state_nx = FINISH;
        end else begin
          state_nx = FILL;
        end
      end
      FILL: begin
        if (abort_s) begin
          state_nx = FINISH;
        end else begin
          fb_wen_nx  = 1'b1;
          fb_addr_nx = row_base_r + ADDR_W'(col_r);
          fb_din_nx  = color_r;
          if ({1'b0, col_r} == ew_r - (X_W+1)'(1)) begin
            col_nx      = X_W'(0);
            row_nx      = row_r + Y_W'(1);
            row_base_nx = row_base_r + ROW_STEP;
            if ({1'b0, row_r} == eh_r - (Y_W+1)'(1)) begin
              state_nx = FINISH;
            end else begin
              state_nx = FILL;
            end
          end else begin
            col_nx = col_r + X_W'(1);
          end
        end
      end
      FINISH: begin
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_r    <= IDLE;
      x_r        <= '0;
      y_r        <= '0;
      w_r        <= '0;
      h_r        <= '0;
      color_r    <= '0;
      ew_r       <= '0;
      eh_r       <= '0;
      col_r      <= '0;
      row_r      <= '0;
      row_base_r <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      clipped_r  <= 1'b0;
      fb_wen_r   <= 1'b0;
      fb_addr_r  <= '0;
      fb_din_r   <= '0;
    end else begin
      state_r    <= state_nx;
      x_r        <= x_nx;
      y_r        <= y_nx;
      w_r        <= w_nx;
      h_r        <= h_nx;
      color_r    <= color_nx;
      ew_r       <= ew_nx;
      eh_r       <= eh_nx;
      col_r      <= col_nx;
      row_r      <= row_nx;
      row_base_r <= row_base_nx;
      busy_r     <= busy_nx;
      done_r     <= done_nx;
      clipped_r  <= clipped_nx;
      fb_wen_r   <= fb_wen_nx;
      fb_addr_r  <= fb_addr_nx;
      fb_din_r   <= fb_din_nx;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign clipped = clipped_r;
  assign fb_wen  = fb_wen_r;
  assign fb_addr = fb_addr_r;
  assign fb_din  = fb_din_r;

endmodule

// File: tb/tb_fb_fill_engine.sv
// Self-checking bench for fb_fill_engine: a transaction-level model predicts
// the per-cycle outputs; literal expectations pin the model on known cases.
module tb_fb_fill_engine;

  logic        clock, nreset, start, abort;
  logic [7:0]  rect_x, rect_w;
  logic [6:0]  rect_y, rect_h;
  logic [11:0] color;
  logic        busy, done, clipped, fb_wen;
  logic [14:0] fb_addr;
  logic [11:0] fb_din;

  fb_fill_engine dut (
    .clock(clock), .nreset(nreset), .start(start),
    .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
    .color(color), .abort(abort),
    .busy(busy), .done(done), .clipped(clipped),
    .fb_wen(fb_wen), .fb_addr(fb_addr), .fb_din(fb_din)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each accepted request becomes a timeline: t=0 is the accepting edge,
  // writes occupy t=2..k+1, done at t=k+2, busy for t<k+2.
  logic        exp_busy, exp_done, exp_clip, exp_wen;
  logic [14:0] exp_addr;
  logic [11:0] exp_din;
  bit          m_active;
  int          m_t, m_last_wr, m_done_t;
  bit          m_clip;
  logic [11:0] m_color;
  int          m_q[$];

  function automatic int eff_len(input int pos, input int len, input int lim);
    if (pos >= lim) return 0;
    return (len < lim - pos) ? len : lim - pos;
  endfunction

  always @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      m_active = 1'b0;
      exp_busy = 1'b0; exp_done = 1'b0; exp_clip = 1'b0; exp_wen = 1'b0;
      exp_addr = '0;   exp_din  = '0;
    end else begin
      exp_done = 1'b0;
      exp_wen  = 1'b0;
      if (m_active) begin
        m_t++;
`ifdef FB_FILL_ABORT_EN
        if (abort && m_t <= m_last_wr) begin
          m_last_wr = m_t - 1;
          m_done_t  = m_t + 1;
        end
`endif
        if (m_t == 1) exp_clip = m_clip;
        if (m_t >= 2 && m_t <= m_last_wr) begin
          exp_wen  = 1'b1;
          exp_addr = 15'(m_q.pop_front());
          exp_din  = m_color;
        end
        exp_busy = (m_t < m_done_t);
        if (m_t == m_done_t) begin
          exp_done = 1'b1;
          m_active = 1'b0;
        end
      end else if (start) begin
        int ew, eh;
        ew = eff_len(int'(rect_x), int'(rect_w), 160);
        eh = eff_len(int'(rect_y), int'(rect_h), 120);
        m_clip = (rect_x >= 8'd160) || (rect_y >= 7'd120) ||
                 (ew < int'(rect_w)) || (eh < int'(rect_h));
        m_q.delete();
        for (int r = 0; r < eh; r++)
          for (int c = 0; c < ew; c++)
            m_q.push_back((int'(rect_y) + r) * 160 + int'(rect_x) + c);
        m_last_wr = ew * eh + 1;
        m_done_t  = ew * eh + 2;
        m_color   = color;
        m_t       = 0;
        m_active  = 1'b1;
        exp_busy  = 1'b1;
        exp_clip  = 1'b0;
      end
    end
  end

  // Single compare process: DUT vs model, every cycle, away from posedge.
  bit chk_en = 1'b0;
  always @(negedge clock) begin
    if (chk_en) begin
      check("busy",    32'(busy),    32'(exp_busy));
      check("done",    32'(done),    32'(exp_done));
      check("clipped", 32'(clipped), 32'(exp_clip));
      check("fb_wen",  32'(fb_wen),  32'(exp_wen));
      check("fb_addr", 32'(fb_addr), 32'(exp_addr));
      check("fb_din",  32'(fb_din),  32'(exp_din));
    end
  end

  // ---------------- transaction driver / observer ----------------
  int obs_q[$];
  int busy_cyc, done_cyc, last_wr_cyc, first_wr_cyc, bad_din;
  logic clip_at_done;

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_fill(input logic [7:0] x, input logic [6:0] y,
                          input logic [7:0] w, input logic [6:0] h,
                          input logic [11:0] c, input int restart_at,
                          input int abort_at);
    int cyc;
    obs_q.delete();
    busy_cyc = 0; done_cyc = -1; last_wr_cyc = -1; first_wr_cyc = -1; bad_din = 0;
    clip_at_done = 1'b0;
    rect_x = x; rect_y = y; rect_w = w; rect_h = h; color = c; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    forever begin
      if (fb_wen) begin
        obs_q.push_back(int'(fb_addr));
        if (fb_din !== c) bad_din++;
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
      end
      if (busy) busy_cyc++;
      if (done) begin
        done_cyc = cyc;
        clip_at_done = clipped;
        break;
      end
      if (cyc == restart_at) begin
        start  = 1'b1;
        color  = 12'($urandom);
        rect_x = 8'($urandom);
        rect_y = 7'($urandom);
        rect_w = 8'($urandom);
        rect_h = 7'($urandom);
      end else begin
        start = 1'b0;
      end
      abort = (cyc == abort_at);
      cyc++;
      if (cyc > 25000) begin
        check("timeout", 32'(1), 32'(0));
        break;
      end
      @(negedge clock);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    nreset = 1'b0; start = 1'b0; abort = 1'b0;
    rect_x = '0; rect_y = '0; rect_w = '0; rect_h = '0; color = '0;
    repeat (2) @(negedge clock);
    chk_en = 1'b1;
    check("rst_busy",  32'(busy),    32'(0));
    check("rst_done",  32'(done),    32'(0));
    check("rst_wen",   32'(fb_wen),  32'(0));
    check("rst_addr",  32'(fb_addr), 32'(0));
    check("rst_din",   32'(fb_din),  32'(0));
    nreset = 1'b1;
    repeat (2) @(negedge clock);

    // Single pixel
    run_fill(8'd5, 7'd3, 8'd1, 7'd1, 12'h0A5, -1, -1);
    check("px_count", 32'(obs_q.size()), 32'(1));
    if (obs_q.size() > 0) check("px_addr", 32'(obs_q[0]), 32'(485));
    check("px_din",   32'(bad_din), 32'(0));
    check("px_busy",  32'(busy_cyc), 32'(3));
    check("px_first", 32'(first_wr_cyc), 32'(2));
    check("px_done",  32'(done_cyc), 32'(last_wr_cyc + 1));

    // Full screen, started in the done cycle of the previous fill
    run_fill(8'd0, 7'd0, 8'd160, 7'd120, 12'hF00, -1, -1);
    check("full_count", 32'(obs_q.size()), 32'(19200));
    if (obs_q.size() == 19200) begin
      check("full_first", 32'(obs_q[0]), 32'(0));
      check("full_last",  32'(obs_q[19199]), 32'(19199));
    end
    check("full_din",  32'(bad_din), 32'(0));
    check("full_busy", 32'(busy_cyc), 32'(19202));
    check("full_done", 32'(done_cyc), 32'(last_wr_cyc + 1));
    check("full_clip", 32'(clip_at_done), 32'(0));
    check("full_gap",  32'(last_wr_cyc - first_wr_cyc + 1), 32'(19200));

    // Clipping at the bottom-right corner
    run_fill(8'd150, 7'd110, 8'd20, 7'd20, 12'h3C3, -1, -1);
    check("clip_count", 32'(obs_q.size()), 32'(100));
    if (obs_q.size() == 100) begin
      check("clip_first", 32'(obs_q[0]),  32'(17750));
      check("clip_rowend", 32'(obs_q[9]), 32'(17759));
      check("clip_row2",  32'(obs_q[10]), 32'(17910));
      check("clip_last",  32'(obs_q[99]), 32'(19199));
    end
    check("clip_flag", 32'(clip_at_done), 32'(1));

    // Rejects
    run_fill(8'd200, 7'd0, 8'd4, 7'd4, 12'h111, -1, -1);
    check("rej_count", 32'(obs_q.size()), 32'(0));
    check("rej_busy",  32'(busy_cyc), 32'(2));
    check("rej_clip",  32'(clip_at_done), 32'(1));
    run_fill(8'd10, 7'd10, 8'd0, 7'd5, 12'h222, -1, -1);
    check("w0_count", 32'(obs_q.size()), 32'(0));
    check("w0_clip",  32'(clip_at_done), 32'(0));

    // start pulsed mid-fill is ignored
    run_fill(8'd20, 7'd20, 8'd10, 7'd10, 12'h123, 30, -1);
    check("restart_count", 32'(obs_q.size()), 32'(100));
    check("restart_din",   32'(bad_din), 32'(0));

    // abort in the 5th write cycle
    run_fill(8'd40, 7'd30, 8'd10, 7'd10, 12'h456, -1, 5);
`ifdef FB_FILL_ABORT_EN
    check("abort_count", 32'(obs_q.size()), 32'(4));
`else
    check("abort_count", 32'(obs_q.size()), 32'(100));
`endif

    // Reset in the middle of a fill
    @(negedge clock);
    rect_x = 8'd0; rect_y = 7'd0; rect_w = 8'd50; rect_h = 7'd10; color = 12'hABC;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    #2 nreset = 1'b0;
    #1;
    check("midrst_wen",  32'(fb_wen), 32'(0));
    check("midrst_busy", 32'(busy),   32'(0));
    repeat (2) @(negedge clock);
    nreset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("postrst_wen", 32'(fb_wen), 32'(0));
    end

    // Randomized requests, some with a mid-fill start or an abort
    for (int i = 0; i < 25; i++) begin
      logic [7:0] rx, rw;
      logic [6:0] ry, rh;
      int ew, eh, ra, rb;
      rx = 8'($urandom_range(0, 175));
      ry = 7'($urandom_range(0, 127));
      rw = 8'($urandom_range(0, 40));
      rh = 7'($urandom_range(0, 20));
      ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : -1;
      rb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 30)) : -1;
      ew = eff_len(int'(rx), int'(rw), 160);
      eh = eff_len(int'(ry), int'(rh), 120);
      run_fill(rx, ry, rw, rh, 12'($urandom), ra, rb);
`ifndef FB_FILL_ABORT_EN
      check("rand_count", 32'(obs_q.size()), 32'(ew * eh));
`endif
      check("rand_din", 32'(bad_din), 32'(0));
      if ($urandom_range(0, 1) == 1) @(negedge clock);
    end

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_fill_engine.md
Name: fb_fill_engine

Overview:
- Hardware rectangle-fill writer for the frame buffer's second port (port B).
- The VGA controller reads pixels out of the frame buffer; this block is the writer that bulk-fills pixels in.
- It takes a rectangle and a 12-bit color, clips the rectangle to the screen, and writes one pixel per clock into the frame buffer.
- It reports busy and done to the core or SFR logic.

Parameters:
- FB_WIDTH, 160, pixels per row.
- FB_HEIGHT, 120, rows per frame.
- X_W, 8, width of the x / width fields.
- Y_W, 7, width of the y / height fields.
- ADDR_W, 15, frame buffer address width.
- PIX_W, 12, pixel width (4:4:4 RGB).

Ports:
- clock  input  1  core clock; all state changes on its rising edge.
- nreset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- rect_x  input  X_W  left column.
- rect_y  input  Y_W  top row.
- rect_w  input  X_W  width in pixels.
- rect_h  input  Y_W  height in rows.
- color  input  PIX_W  fill value.
- abort  input  1  cancel request (active only with the optional feature).
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at completion or abort.
- clipped  output  1  sticky per operation: the request was reduced or rejected.
- fb_wen  output  1  frame buffer write enable.
- fb_addr  output  ADDR_W  frame buffer address.
- fb_din  output  PIX_W  frame buffer write data.

Behaviour:
- Reset (async, nreset=0):
  - state=IDLE.
  - busy=0, done=0, clipped=0, fb_wen=0, fb_addr=0, fb_din=0.
  - All internal counters cleared.
  - Reset mid-fill stops writes immediately; the next write after release requires a new start.
- States: IDLE, SETUP, FILL, FINISH.
- IDLE:
  - On start=1, latch rect_x, rect_y, rect_w, rect_h and color.
  - Clear clipped, set busy, go to SETUP.
  - start while not IDLE is ignored; it is neither queued nor relatched.
- SETUP (1 cycle):
  - Compute effective width: ew = min(rect_w, FB_WIDTH - rect_x).
  - Compute effective height: eh = min(rect_h, FB_HEIGHT - rect_y).
  - Compute row_base = rect_y*FB_WIDTH + rect_x, with no wrap; it fits ADDR_W for legal coordinates.
  - If rect_x>=FB_WIDTH, rect_y>=FB_HEIGHT, rect_w==0 or rect_h==0: go to FINISH with no writes. clipped=1 unless only w or h is zero.
  - Set clipped=1 if ew<rect_w or eh<rect_h.
  - Otherwise go to FILL with col=0, row=0.
- FILL:
  - Each cycle: fb_wen=1, fb_addr=row_base+col, fb_din=latched color.
  - When col==ew-1: col=0, row_base+=FB_WIDTH, row++.
  - When the last pixel (row==eh-1, col==ew-1) is written, go to FINISH.
  - Writes are strictly consecutive with no gaps; ew*eh write cycles total.
  - Address is row-major and never wraps across a row.
- FINISH (1 cycle):
  - fb_wen=0, done=1, busy=0 in that same cycle, return to IDLE.
  - A start in the cycle after done is accepted.
- Latency:
  - start sampled at edge N → first fb_wen high in the cycle after edge N+2.
  - done high in the cycle after the last write.
  - Total busy cycles = ew*eh + 2.
- fb_wen is low in every state except FILL.
- fb_addr and fb_din hold their last values when idle.

Optional Feature:
- Macro: FB_FILL_ABORT_EN.
- With the macro defined:
  - abort=1 in SETUP or FILL ends the operation; that cycle has no write.
  - Go to FINISH: done pulses next cycle and busy drops with it.
  - Pixels already written remain.
  - abort in IDLE or FINISH has no effect.
- Without the macro: the abort port exists but is ignored; logic is not synthesized.

Test Plan:
- Full screen: start with x=0, y=0, w=160, h=120, color=0xF00 → exactly 19200 consecutive writes.
  - First fb_addr=0, last fb_addr=19199, all fb_din=0xF00.
  - done one cycle after the last write; clipped=0; busy high for 19202 cycles.
- Single pixel: x=5, y=3, w=1, h=1, color=0x0A5 → one write at addr 485, data 0x0A5.
  - done 2 cycles after that write's start sample plus 1, i.e. busy for 3 cycles.
- Clipping: x=150, y=110, w=20, h=20 → 100 writes.
  - First addr 17750; row ends 17759; next row starts 17910; last addr 19199; clipped=1.
- Rejects:
  - x=200, y=0, w=4, h=4 → zero writes, done after 2 busy cycles, clipped=1.
  - w=0 → zero writes, clipped=0.
- Busy and reset:
  - Pulse start again mid-fill with a different color → ignored; write count and data unchanged.
  - Separately, drop nreset mid-fill → fb_wen=0 and busy=0 immediately; no writes until a new start.
- Abort (FB_FILL_ABORT_EN): 10x10 fill, abort asserted in the 5th write cycle → exactly 4 writes, done next cycle.
  - Without the macro, the same stimulus gives 100 writes.
